uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Transmit-side UART framer, the counterpart of the receive path and its overrun detection. Pops bytes from the TX FIFO with a registered-read handshake and serialises each as start bit, LSB-first data, optional parity and 1–2 stop bits on `tx`. Flags underrun-free completion per frame, and never reads an empty FIFO.

## Interface
- `CLKS_PER_BIT`, 868: clocks per bit period (≥2); 868 gives 115200 baud at 100 MHz.
- `DATA_BITS`, 8: data bits per frame (5–8).
- `PARITY_EN`, 0: 1 appends a parity bit after the data.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits (1 or 2).
- `clk`  in  1  sole clock; everything is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tx_en`  in  1  permits starting new frames; a frame in flight always completes.
- `fifo_empty`  in  1  TX FIFO empty flag.
- `fifo_rdata`  in  DATA_BITS  FIFO read data; valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  one-cycle FIFO pop strobe.
- `tx`  out  1  serial line; idles high.
- `tx_busy`  out  1  high in every state except IDLE.
- `tx_done`  out  1  one-cycle pulse after the final stop bit.

## Operation
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. If `tx_en` && !`fifo_empty`, assert `fifo_rd_en` this cycle and go to FETCH. Otherwise hold.
- FETCH (1 cycle): `tx`=1. Latch `fifo_rdata` into the shift register, clear the baud and bit counters, and go to START.
- START: `tx`=0 for `CLKS_PER_BIT` clocks, then go to DATA.
- DATA: `tx` = shift_reg[0], held `CLKS_PER_BIT` clocks per bit. Shift right at each bit boundary. After bit `DATA_BITS-1`, go to PARITY if `PARITY_EN`, else to STOP.
- PARITY: `tx` = XOR of the latched data bits, XOR `PARITY_ODD`, held one bit period.
- STOP: `tx`=1 for `STOP_BITS` bit periods, then go to IDLE.
- Baud counter runs 0..`CLKS_PER_BIT`-1. Its terminal count is the bit boundary. Bit counter width is $clog2(DATA_BITS).
- `fifo_empty` is sampled only in IDLE. `fifo_rd_en` is never asserted outside IDLE and never asserted while `fifo_empty`=1.
- Deasserting `tx_en` mid-frame has no effect on the current frame and prevents the next fetch.
- Changes to `fifo_rdata` after FETCH do not affect the frame in flight.

## Timing
- Reset values: `tx`=1, `fifo_rd_en`=0, `tx_busy`=0, `tx_done`=0, state=IDLE, counters=0.
- Reset asserted mid-frame forces `tx` high immediately (async) and aborts the frame. The popped byte is lost.
- Latency:
  - `fifo_rd_en` high in cycle t.
  - FETCH in cycle t+1.
  - `tx` falls at t+2.
- Frame length from the START edge to IDLE entry: `CLKS_PER_BIT`×(1+`DATA_BITS`+`PARITY_EN`+`STOP_BITS`) clocks exactly.
- `tx_done` is high in the first IDLE cycle after STOP; `tx_busy` is low in that same cycle. `fifo_rd_en` may assert in that same cycle.
- Back-to-back frames therefore have exactly 2 extra high clocks (IDLE + FETCH) between the stop-bit end and the next start bit.
- `tx`, `fifo_rd_en`, `tx_busy` and `tx_done` are registered outputs (no combinational path from inputs).

## Structure
- `uart_pkg` holds:
  - the state enum `uart_tx_state_t` (shared naming with the RX FSM);
  - parity constants `PAR_EVEN`/`PAR_ODD`;
  - default `CLKS_PER_BIT` localparam.
- One natural sub-module: `uart_baud_counter`, a parameterised terminal-count counter with `clear` and `tick` outputs. It is reusable by the RX sampler.
- Shift register, bit counter and FSM stay in `uart_tx_engine`.

## Test plan
- Use `CLKS_PER_BIT`=4 for all scenarios.
- Single byte, 8N1: FIFO holds 0xA5, `tx_en`=1.
  - Exactly one `fifo_rd_en` pulse.
  - `tx` bits 0,1,0,1,0,0,1,0,1,1, each 4 clocks; 40 clocks total.
  - `tx_done` pulses once; `tx_busy` high for 42 clocks.
- Parity: 0xA5 with `PARITY_EN`=1.
  - Even: parity bit = 0; frame = 44 clocks.
  - `PARITY_ODD`=1: parity bit = 1.
- Back-to-back: FIFO holds 0x00, 0xFF, `STOP_BITS`=2.
  - Two pops.
  - Exactly 8 stop clocks + 2 idle clocks high between the first frame's last data bit and the second start bit.
- Empty/enable:
  - `fifo_empty`=1 for 100 clocks → no `fifo_rd_en`, `tx`=1.
  - `tx_en` dropped during DATA of 0x3C → frame completes, no further pop though FIFO non-empty.
- Reset mid-frame: assert `rst`=0 during the DATA bit 3 of 0x5A.
  - `tx`=1 and `tx_busy`=0 immediately.
  - After release, the next byte 0x81 transmits correctly with a single pop.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity selectors and default baud divisor
package uart_pkg;
   typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} uart_tx_state_t;
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;
   localparam int DEFAULT_CLKS_PER_BIT = 868;
endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: free-running 0..CLKS-1 counter with synchronous clear and terminal-count tick
module uart_baud_counter #(
   parameter int CLKS = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);
   localparam int W = (CLKS > 1) ? $clog2(CLKS) : 1;
   localparam logic [W-1:0] LAST = W'(CLKS - 1);
   logic [W-1:0] cnt_q, cnt_d;
   assign tick = (cnt_q == LAST);
   always_comb cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmit framer popping bytes from a registered-read FIFO
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_en,
   input  logic                 fifo_empty,
   input  logic [DATA_BITS-1:0] fifo_rdata,
   output logic                 fifo_rd_en,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   localparam logic PAR_INIT = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
   uart_tx_state_t state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BW-1:0] bit_q, bit_d;
   logic par_q, par_d, rd_en_q, rd_en_d, tx_q, tx_d, busy_q, busy_d, done_q, done_d;
   logic tick, clear;
   assign clear = (state_q == IDLE) || (state_q == FETCH);
   uart_baud_counter #(.CLKS(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .tick  (tick)
   );
   // Pop decision is registered one cycle ahead so the strobe lands in the IDLE cycle itself;
   // the FIFO is only drained by us, so a non-empty sample cannot turn stale in between.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      par_d   = par_q;
      rd_en_d = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_en_q) state_d = FETCH;
            else rd_en_d = tx_en && !fifo_empty;
         end
         FETCH: begin
            shift_d = fifo_rdata;
            par_d   = (^fifo_rdata) ^ PAR_INIT;
            bit_d   = '0;
            state_d = START;
         end
         START: state_d = tick ? DATA : START;
         DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 1'b1;
               if (bit_q == LAST_DATA) begin
                  bit_d   = '0;
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
         end
         PARITY: state_d = tick ? STOP : PARITY;
         STOP: begin
            if (tick) begin
               bit_d = bit_q + 1'b1;
               if (bit_q == LAST_STOP) begin
                  bit_d   = '0;
                  state_d = IDLE;
                  done_d  = 1'b1;
                  rd_en_d = tx_en && !fifo_empty;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      tx_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : (state_d == PARITY) ? par_d : 1'b1;
      busy_d = (state_d != IDLE) || (rd_en_d && !done_d);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         par_q   <= 1'b0;
         rd_en_q <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         par_q   <= par_d;
         rd_en_q <= rd_en_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign fifo_rd_en = rd_en_q;
   assign tx         = tx_q;
   assign tx_busy    = busy_q;
   assign tx_done    = done_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: four framer configurations (8N1, 8E1, 8O1, 8N2) against a frame-level line model
module tb_uart_tx_engine;
   localparam int CLKS = 4;
   localparam int MAXS = 400;
   localparam logic [3:0] PE  = 4'b0110;
   localparam logic [3:0] PO  = 4'b0100;
   localparam logic [3:0] SB2 = 4'b1000;
   logic clk = 1'b0;
   logic rst;
   logic [3:0] tx_en, fifo_empty, rd_en, tx, busy, done;
   logic [7:0] rdata [4];
   logic [7:0] mem [4][32];
   int head [4] = '{0, 0, 0, 0};
   int tail [4] = '{0, 0, 0, 0};
   logic bad_pop = 1'b0;
   int errors = 0;
   int checks = 0;
   logic cap_tx [MAXS], cap_rd [MAXS], cap_done [MAXS], cap_busy [MAXS];
   logic exp_tx [MAXS], exp_rd [MAXS], exp_done [MAXS], exp_busy [MAXS];
   logic [7:0] fb [8];
   always #5 clk = ~clk;
   for (genvar g = 0; g < 4; g++) begin : g_dut
      uart_tx_engine #(
         .CLKS_PER_BIT (CLKS),
         .DATA_BITS    (8),
         .PARITY_EN    (int'(PE[g])),
         .PARITY_ODD   (int'(PO[g])),
         .STOP_BITS    (SB2[g] ? 2 : 1)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .tx_en      (tx_en[g]),
         .fifo_empty (fifo_empty[g]),
         .fifo_rdata (rdata[g]),
         .fifo_rd_en (rd_en[g]),
         .tx         (tx[g]),
         .tx_busy    (busy[g]),
         .tx_done    (done[g])
      );
   end
   // Registered-read FIFO model; read data is scrambled on every non-pop edge
   always @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (rd_en[i]) begin
            if (head[i] == tail[i]) bad_pop <= 1'b1;
            rdata[i] <= mem[i][head[i] % 32];
            head[i]  <= head[i] + 1;
         end else rdata[i] <= 8'($urandom);
   always_comb begin
      fifo_empty = '0;
      for (int i = 0; i < 4; i++) fifo_empty[i] = (head[i] == tail[i]);
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic push(input int d, input logic [7:0] b);
      mem[d][tail[d] % 32] = b;
      tail[d] = tail[d] + 1;
   endtask
   task automatic capture(input int d, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         cap_tx[k]   = tx[d];
         cap_rd[k]   = rd_en[d];
         cap_done[k] = done[d];
         cap_busy[k] = busy[d];
      end
   endtask
   function automatic logic fbit(input int d, input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
      if (i == 9 && PE[d]) return (^b) ^ PO[d];
      return 1'b1;
   endfunction
   function automatic int ones(input int sel, input int n);
      int c = 0;
      for (int k = 0; k < n; k++)
         c += int'(sel == 0 ? cap_rd[k] : sel == 1 ? cap_done[k] : cap_busy[k]);
      return c;
   endfunction
   // Expected line: per frame, one pop cycle, one fetch cycle, then each frame bit for CLKS clocks
   task automatic check_trace(input int d, input int nb, input int n, input string tag);
      int nbits = 9 + int'(PE[d]) + (SB2[d] ? 2 : 1);
      int len = 2 + CLKS * nbits;
      int s = 0;
      for (int k = 0; k < n; k++) begin
         exp_tx[k] = 1'b1; exp_rd[k] = 1'b0; exp_done[k] = 1'b0; exp_busy[k] = 1'b0;
      end
      for (int f = 0; f < nb; f++) begin
         for (int j = 0; j < len && s + j < n; j++) begin
            exp_busy[s+j] = (j > 0) || (f == 0);
            exp_rd[s+j]   = (j == 0);
            exp_done[s+j] = (j == 0) && (f > 0);
            if (j >= 2) exp_tx[s+j] = fbit(d, fb[f], (j - 2) / CLKS);
         end
         s += len;
      end
      if (nb > 0 && s < n) exp_done[s] = 1'b1;
      for (int k = 0; k < n; k++) begin
         chk($sformatf("%s d%0d tx[%0d]", tag, d, k), 32'(cap_tx[k]), 32'(exp_tx[k]));
         chk($sformatf("%s d%0d rd[%0d]", tag, d, k), 32'(cap_rd[k]), 32'(exp_rd[k]));
         chk($sformatf("%s d%0d done[%0d]", tag, d, k), 32'(cap_done[k]), 32'(exp_done[k]));
         chk($sformatf("%s d%0d busy[%0d]", tag, d, k), 32'(cap_busy[k]), 32'(exp_busy[k]));
      end
   endtask
   initial begin
      int run;
      rst = 1'b0;
      tx_en = '0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("reset tx d%0d", d), 32'(tx[d]), 32'd1);
         chk($sformatf("reset rd d%0d", d), 32'(rd_en[d]), 32'd0);
         chk($sformatf("reset busy d%0d", d), 32'(busy[d]), 32'd0);
         chk($sformatf("reset done d%0d", d), 32'(done[d]), 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      // 8N1 0xA5
      fb[0] = 8'hA5;
      push(0, fb[0]);
      tx_en[0] = 1'b1;
      capture(0, 50);
      tx_en[0] = 1'b0;
      check_trace(0, 1, 50, "8n1");
      chk("8n1 pops", ones(0, 50), 1);
      chk("8n1 done pulses", ones(1, 50), 1);
      chk("8n1 busy clocks", ones(2, 50), 42);
      // Even and odd parity on 0xA5
      for (int d = 1; d <= 2; d++) begin
         push(d, fb[0]);
         tx_en[d] = 1'b1;
         capture(d, 50);
         tx_en[d] = 1'b0;
         check_trace(d, 1, 50, "par");
         chk($sformatf("parity bit d%0d", d), 32'(cap_tx[2 + CLKS * 9 + 1]), (d == 2) ? 32'd1 : 32'd0);
         chk($sformatf("parity busy d%0d", d), ones(2, 50), 46);
      end
      // Back-to-back 0x00, 0xFF with two stop bits
      fb[0] = 8'h00;
      fb[1] = 8'hFF;
      push(3, fb[0]);
      push(3, fb[1]);
      tx_en[3] = 1'b1;
      capture(3, 100);
      tx_en[3] = 1'b0;
      check_trace(3, 2, 100, "b2b");
      chk("b2b pops", ones(0, 100), 2);
      run = 0;
      for (int k = 2 + CLKS * 9; k < 100 && cap_tx[k] === 1'b1; k++) run++;
      chk("b2b gap high clocks", run, 10);
      // Random bytes, three back-to-back frames per configuration
      for (int d = 0; d < 4; d++) begin
         for (int f = 0; f < 3; f++) begin
            fb[f] = 8'($urandom);
            push(d, fb[f]);
         end
         tx_en[d] = 1'b1;
         capture(d, 150);
         tx_en[d] = 1'b0;
         check_trace(d, 3, 150, "rand");
         chk($sformatf("rand pops d%0d", d), ones(0, 150), 3);
      end
      // Empty FIFO with enable held
      tx_en[0] = 1'b1;
      capture(0, 100);
      tx_en[0] = 1'b0;
      check_trace(0, 0, 100, "empty");
      chk("empty pops", ones(0, 100), 0);
      // Enable dropped mid-DATA of 0x3C with another byte waiting
      fb[0] = 8'h3C;
      push(1, fb[0]);
      push(1, 8'h99);
      tx_en[1] = 1'b1;
      fork
         capture(1, 100);
         begin
            repeat (20) @(negedge clk);
            tx_en[1] = 1'b0;
         end
      join
      check_trace(1, 1, 100, "txen");
      chk("txen pops", ones(0, 100), 1);
      chk("txen fifo left", tail[1] - head[1], 1);
      // Reset during DATA bit 3 of 0x5A, then 0x81
      push(0, 8'h5A);
      tx_en[0] = 1'b1;
      repeat (20) @(negedge clk);
      chk("pre-reset busy", 32'(busy[0]), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid reset tx", 32'(tx[0]), 32'd1);
      chk("mid reset busy", 32'(busy[0]), 32'd0);
      fb[0] = 8'h81;
      push(0, fb[0]);
      @(negedge clk);
      rst = 1'b1;
      capture(0, 60);
      tx_en[0] = 1'b0;
      check_trace(0, 1, 60, "postrst");
      chk("postrst pops", ones(0, 60), 1);
      chk("no empty pop", 32'(bad_pop), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
